ex_stage: RTL and testbench



---
 rtl/ex_stage.sv | 190 +++++++++++++++++++
 tb/tb_ex_stage.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute pipeline stage of the RV64I core.
//
// Holds the decode->execute pipeline register and evaluates it through a
// one-hot ALU. The result is presented to the memory stage under a
// valid/allowin handshake, along with a same-cycle forwarding tap.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   flush                     kill held instruction, block capture this cycle
//   ds_valid / es_allowin     decode -> execute handshake
//   ds_pc, ds_alu_op, ds_src1, ds_src2, ds_word, ds_rd, ds_rf_we
//                             incoming instruction payload
//   ms_allowin                memory stage can accept
//   es_to_ms_valid            result valid toward memory stage
//   es_pc, es_result, es_rd, es_rf_we
//                             registered instruction and its result
//   es_fwd_valid, es_fwd_rd, es_fwd_data
//                             forwarding tap (x0 never forwards)
//   es_stall_cnt              cycles spent holding a result under back-pressure

// One-hot ALU. Op order, MSB first:
//   add sub sll sllw slt sltu xor srl srlw sra sraw or and
// Word ops produce correct low 32 bits only; the caller sign-extends.
module alu #(
  parameter int XLEN = 64,
  parameter int OPW  = 13
) (
  input  logic [OPW-1:0]  alu_op,
  input  logic [XLEN-1:0] alu_src1,
  input  logic [XLEN-1:0] alu_src2,
  output logic [XLEN-1:0] alu_result
);
  logic [XLEN-1:0] op_res [OPW];
  logic [XLEN-1:0] masked [OPW];
  logic [31:0]     sllw_res;
  logic [31:0]     srlw_res;
  logic [31:0]     sraw_res;
  logic [XLEN-1:0] sra_res;

  // Shift amounts are masked to 6 bits (64-bit) or 5 bits (word).
  assign sllw_res = alu_src1[31:0] << alu_src2[4:0];
  assign srlw_res = alu_src1[31:0] >> alu_src2[4:0];
  assign sraw_res = $signed(alu_src1[31:0]) >>> alu_src2[4:0];
  assign sra_res  = $signed(alu_src1) >>> alu_src2[5:0];

  assign op_res[12] = alu_src1 + alu_src2;
  assign op_res[11] = alu_src1 - alu_src2;
  assign op_res[10] = alu_src1 << alu_src2[5:0];
  assign op_res[9]  = {{(XLEN-32){1'b0}}, sllw_res};
  assign op_res[8]  = {{(XLEN-1){1'b0}}, $signed(alu_src1) < $signed(alu_src2)};
  assign op_res[7]  = {{(XLEN-1){1'b0}}, alu_src1 < alu_src2};
  assign op_res[6]  = alu_src1 ^ alu_src2;
  assign op_res[5]  = alu_src1 >> alu_src2[5:0];
  assign op_res[4]  = {{(XLEN-32){1'b0}}, srlw_res};
  assign op_res[3]  = sra_res;
  assign op_res[2]  = {{(XLEN-32){1'b0}}, sraw_res};
  assign op_res[1]  = alu_src1 | alu_src2;
  assign op_res[0]  = alu_src1 & alu_src2;

  // One-hot select: gate each candidate by its op bit, then OR together.
  // An all-zero op therefore yields zero.
  genvar gi;
  generate
    for (gi = 0; gi < OPW; gi++) begin : g_mask
      assign masked[gi] = {XLEN{alu_op[gi]}} & op_res[gi];
    end
  endgenerate

  always_comb begin
    alu_result = '0;
    for (int i = 0; i < OPW; i++) begin
      alu_result = alu_result | masked[i];
    end
  end
endmodule

module ex_stage #(
  parameter int XLEN = 64,
  parameter int OPW  = 13
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            ds_valid,
  output logic            es_allowin,
  input  logic [XLEN-1:0] ds_pc,
  input  logic [OPW-1:0]  ds_alu_op,
  input  logic [XLEN-1:0] ds_src1,
  input  logic [XLEN-1:0] ds_src2,
  input  logic            ds_word,
  input  logic [4:0]      ds_rd,
  input  logic            ds_rf_we,
  input  logic            ms_allowin,
  output logic            es_to_ms_valid,
  output logic [XLEN-1:0] es_pc,
  output logic [XLEN-1:0] es_result,
  output logic [4:0]      es_rd,
  output logic            es_rf_we,
  output logic            es_fwd_valid,
  output logic [4:0]      es_fwd_rd,
  output logic [XLEN-1:0] es_fwd_data,
  output logic [31:0]     es_stall_cnt
);
  logic            es_valid_reg;
  logic            es_valid_next;
  logic [XLEN-1:0] pc_reg;
  logic [OPW-1:0]  alu_op_reg;
  logic [XLEN-1:0] src1_reg;
  logic [XLEN-1:0] src2_reg;
  logic            word_reg;
  logic [4:0]      rd_reg;
  logic            rf_we_reg;
  logic [31:0]     stall_cnt_reg;
  logic [31:0]     stall_cnt_next;
  logic            es_ready_go;
  logic            load_en;
  logic [XLEN-1:0] alu_result;

  // Every ALU op completes in a single cycle.
  assign es_ready_go = 1'b1;
  assign es_allowin  = !es_valid_reg | (es_ready_go & ms_allowin);
  assign load_en     = es_allowin & ds_valid & !flush;

  always_comb begin
    es_valid_next  = es_valid_reg;
    stall_cnt_next = stall_cnt_reg;
    if (flush) begin
      es_valid_next = 1'b0;
    end else if (es_allowin) begin
      es_valid_next = ds_valid;
    end
    // A flushed cycle is not a stall: the held instruction is dead.
    if (es_valid_reg & !ms_allowin & !flush) begin
      stall_cnt_next = stall_cnt_reg + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      es_valid_reg  <= 1'b0;
      stall_cnt_reg <= '0;
    end else begin
      es_valid_reg  <= es_valid_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg     <= '0;
      alu_op_reg <= '0;
      src1_reg   <= '0;
      src2_reg   <= '0;
      word_reg   <= 1'b0;
      rd_reg     <= '0;
      rf_we_reg  <= 1'b0;
    end else if (load_en) begin
      pc_reg     <= ds_pc;
      alu_op_reg <= ds_alu_op;
      src1_reg   <= ds_src1;
      src2_reg   <= ds_src2;
      word_reg   <= ds_word;
      rd_reg     <= ds_rd;
      rf_we_reg  <= ds_rf_we;
    end
  end

  alu #(
    .XLEN(XLEN),
    .OPW (OPW)
  ) u_alu (
    .alu_op    (alu_op_reg),
    .alu_src1  (src1_reg),
    .alu_src2  (src2_reg),
    .alu_result(alu_result)
  );

  assign es_result = word_reg ? {{(XLEN-32){alu_result[31]}}, alu_result[31:0]}
                              : alu_result;

  // flush only suppresses the handoff; the forwarding tap follows es_valid.
  assign es_to_ms_valid = es_valid_reg & es_ready_go & !flush;
  assign es_pc          = pc_reg;
  assign es_rd          = rd_reg;
  assign es_rf_we       = es_valid_reg & rf_we_reg;
  assign es_fwd_valid   = es_valid_reg & rf_we_reg & (rd_reg != 5'd0);
  assign es_fwd_rd      = rd_reg;
  assign es_fwd_data    = es_result;
  assign es_stall_cnt   = stall_cnt_reg;
endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: directed vectors, scoreboard queue filled at
// issue time and drained by an independent monitor on each handoff.
module tb_ex_stage;
  localparam logic [12:0] OP_ADD  = 13'h1000;
  localparam logic [12:0] OP_SUB  = 13'h0800;
  localparam logic [12:0] OP_SLL  = 13'h0400;
  localparam logic [12:0] OP_SLLW = 13'h0200;
  localparam logic [12:0] OP_SLT  = 13'h0100;
  localparam logic [12:0] OP_SLTU = 13'h0080;
  localparam logic [12:0] OP_XOR  = 13'h0040;
  localparam logic [12:0] OP_SRL  = 13'h0020;
  localparam logic [12:0] OP_SRLW = 13'h0010;
  localparam logic [12:0] OP_SRA  = 13'h0008;
  localparam logic [12:0] OP_SRAW = 13'h0004;
  localparam logic [12:0] OP_OR   = 13'h0002;
  localparam logic [12:0] OP_AND  = 13'h0001;
  localparam logic [12:0] OP_NONE = 13'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        ds_valid = 1'b0;
  logic        es_allowin;
  logic [63:0] ds_pc = '0;
  logic [12:0] ds_alu_op = '0;
  logic [63:0] ds_src1 = '0;
  logic [63:0] ds_src2 = '0;
  logic        ds_word = 1'b0;
  logic [4:0]  ds_rd = '0;
  logic        ds_rf_we = 1'b0;
  logic        ms_allowin = 1'b1;
  logic        es_to_ms_valid;
  logic [63:0] es_pc;
  logic [63:0] es_result;
  logic [4:0]  es_rd;
  logic        es_rf_we;
  logic        es_fwd_valid;
  logic [4:0]  es_fwd_rd;
  logic [63:0] es_fwd_data;
  logic [31:0] es_stall_cnt;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] res;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] pc_ctr = 64'h1000;
  logic [63:0] held_pc;

  ex_stage dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .ds_valid      (ds_valid),
    .es_allowin    (es_allowin),
    .ds_pc         (ds_pc),
    .ds_alu_op     (ds_alu_op),
    .ds_src1       (ds_src1),
    .ds_src2       (ds_src2),
    .ds_word       (ds_word),
    .ds_rd         (ds_rd),
    .ds_rf_we      (ds_rf_we),
    .ms_allowin    (ms_allowin),
    .es_to_ms_valid(es_to_ms_valid),
    .es_pc         (es_pc),
    .es_result     (es_result),
    .es_rd         (es_rd),
    .es_rf_we      (es_rf_we),
    .es_fwd_valid  (es_fwd_valid),
    .es_fwd_rd     (es_fwd_rd),
    .es_fwd_data   (es_fwd_data),
    .es_stall_cnt  (es_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual 0x%h required 0x%h", name, act, req);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %b required %b", name, act, req);
    end
  endtask

  // Drive an instruction (call at posedge+1), wait for acceptance, record the
  // expected result, and return at posedge+1 with ds_valid still high.
  task automatic issue(input logic [12:0] op, input logic [63:0] s1, input logic [63:0] s2,
                       input logic w, input logic [4:0] rd, input logic we, input logic [63:0] res);
    int   n = 0;
    exp_t e;
    ds_pc     = pc_ctr;
    ds_alu_op = op;
    ds_src1   = s1;
    ds_src2   = s2;
    ds_word   = w;
    ds_rd     = rd;
    ds_rf_we  = we;
    ds_valid  = 1'b1;
    @(negedge clk);
    while (!es_allowin && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!es_allowin) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: actual allowin=0 required allowin=1 pc=0x%h", pc_ctr);
    end else begin
      e.pc  = pc_ctr;
      e.res = res;
      e.rd  = rd;
      e.we  = we;
      exp_q.push_back(e);
    end
    pc_ctr = pc_ctr + 64'd4;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handoff to the memory stage pops one expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && es_to_ms_valid && ms_allowin) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: actual pc=0x%h result=0x%h required no output", es_pc, es_result);
      end else begin
        e = exp_q.pop_front();
        $display("xfer pc=0x%h result=0x%h rd=%0d we=%b fwd=%b", es_pc, es_result, es_rd, es_rf_we, es_fwd_valid);
        check("mon_result", es_result, e.res);
        check("mon_pc", es_pc, e.pc);
        check("mon_rd", 64'(es_rd), 64'(e.rd));
        check_bit("mon_rf_we", es_rf_we, e.we);
        check_bit("mon_fwd_valid", es_fwd_valid, e.we && (e.rd != 5'd0));
        check("mon_fwd_rd", 64'(es_fwd_rd), 64'(e.rd));
        check("mon_fwd_data", es_fwd_data, e.res);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

  initial begin
    // Reset values while rst is held.
    @(negedge clk);
    check_bit("rst_to_ms_valid", es_to_ms_valid, 1'b0);
    check_bit("rst_allowin", es_allowin, 1'b1);
    check("rst_result", es_result, 64'd0);
    check("rst_stall_cnt", 64'(es_stall_cnt), 64'd0);
    check_bit("rst_rf_we", es_rf_we, 1'b0);
    check_bit("rst_fwd_valid", es_fwd_valid, 1'b0);
    check("rst_pc", es_pc, 64'd0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Back-pressure: add 3+4 held for three cycles with a new one waiting.
    issue(OP_ADD, 64'd3, 64'd4, 1'b0, 5'd5, 1'b1, 64'd7);
    ms_allowin = 1'b0;
    ds_pc      = pc_ctr;
    ds_alu_op  = OP_ADD;
    ds_src1    = 64'd10;
    ds_src2    = 64'd20;
    ds_word    = 1'b0;
    ds_rd      = 5'd6;
    ds_rf_we   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_result", es_result, 64'd7);
      check_bit("bp_allowin", es_allowin, 1'b0);
      check_bit("bp_to_ms_valid", es_to_ms_valid, 1'b1);
      check_bit("bp_fwd_valid", es_fwd_valid, 1'b1);
      @(posedge clk);
      #1;
    end
    check("bp_stall_cnt", 64'(es_stall_cnt), 64'd3);
    ms_allowin = 1'b1;
    begin
      exp_t e;
      e.pc  = pc_ctr;
      e.res = 64'd30;
      e.rd  = 5'd6;
      e.we  = 1'b1;
      exp_q.push_back(e);
    end
    pc_ctr = pc_ctr + 64'd4;
    @(negedge clk);
    check_bit("bp_allowin_release", es_allowin, 1'b1);
    @(posedge clk);
    #1;
    ds_valid = 1'b0;
    check("bp_next_result", es_result, 64'd30);
    check("bp_stall_hold", 64'(es_stall_cnt), 64'd3);

    // Word sign extension.
    issue(OP_ADD, 64'h7FFF_FFFF, 64'd1, 1'b1, 5'd1, 1'b1, 64'hFFFF_FFFF_8000_0000);
    issue(OP_ADD, 64'h7FFF_FFFF, 64'd1, 1'b0, 5'd1, 1'b1, 64'h0000_0000_8000_0000);

    // Back-to-back throughput.
    issue(OP_SUB,  64'd10, 64'd3, 1'b0, 5'd2, 1'b1, 64'd7);
    issue(OP_SLTU, 64'd1,  64'd2, 1'b0, 5'd3, 1'b1, 64'd1);
    issue(OP_SRAW, 64'h8000_0000, 64'd4, 1'b1, 5'd4, 1'b1, 64'hFFFF_FFFF_F800_0000);
    ds_valid = 1'b0;
    @(posedge clk);
    #1;
    check("b2b_drained", 64'(exp_q.size()), 64'd0);

    // Remaining ops, including shift-amount masking.
    issue(OP_SLL,  64'd1, 64'd65, 1'b0, 5'd8, 1'b1, 64'd2);
    issue(OP_SLLW, 64'd1, 64'd31, 1'b1, 5'd8, 1'b1, 64'hFFFF_FFFF_8000_0000);
    issue(OP_SLT,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 5'd8, 1'b1, 64'd1);
    issue(OP_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 5'd8, 1'b1, 64'd0);
    issue(OP_XOR,  64'hF0F0, 64'h0FF0, 1'b0, 5'd8, 1'b1, 64'hFF00);
    issue(OP_SRL,  64'h8000_0000_0000_0000, 64'd63, 1'b0, 5'd8, 1'b1, 64'd1);
    issue(OP_SRLW, 64'hFFFF_FFFF_8000_0000, 64'd4, 1'b1, 5'd8, 1'b1, 64'h0000_0000_0800_0000);
    issue(OP_SRA,  64'h8000_0000_0000_0000, 64'd4, 1'b0, 5'd8, 1'b1, 64'hF800_0000_0000_0000);
    issue(OP_OR,   64'hA, 64'h5, 1'b0, 5'd8, 1'b0, 64'hF);
    issue(OP_AND,  64'hC, 64'hA, 1'b0, 5'd8, 1'b1, 64'h8);
    issue(OP_NONE, 64'h1234, 64'h5678, 1'b0, 5'd8, 1'b1, 64'd0);
    issue(OP_SUB,  64'd0, 64'd1, 1'b1, 5'd8, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);

    // Forwarding on x0.
    issue(OP_ADD, 64'd5, 64'd6, 1'b0, 5'd0, 1'b1, 64'd11);
    ds_valid = 1'b0;
    @(negedge clk);
    check_bit("x0_to_ms_valid", es_to_ms_valid, 1'b1);
    check_bit("x0_fwd_valid", es_fwd_valid, 1'b0);
    @(posedge clk);
    #1;

    // Flush with an instruction held and a new one offered.
    held_pc = pc_ctr;
    issue(OP_ADD, 64'd100, 64'd1, 1'b0, 5'd3, 1'b1, 64'd101);
    ms_allowin = 1'b0;
    ds_valid   = 1'b0;
    @(negedge clk);
    check_bit("flush_pre_valid", es_to_ms_valid, 1'b1);
    @(posedge clk);
    #1;
    check("flush_pre_stall", 64'(es_stall_cnt), 64'd4);
    flush     = 1'b1;
    ds_pc     = 64'hDEAD_0000;
    ds_alu_op = OP_ADD;
    ds_src1   = 64'd1;
    ds_src2   = 64'd1;
    ds_rd     = 5'd7;
    ds_rf_we  = 1'b1;
    ds_valid  = 1'b1;
    @(negedge clk);
    check_bit("flush_to_ms_valid", es_to_ms_valid, 1'b0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    ds_valid = 1'b0;
    check_bit("flush_after_allowin", es_allowin, 1'b1);
    check_bit("flush_after_to_ms", es_to_ms_valid, 1'b0);
    check_bit("flush_after_rf_we", es_rf_we, 1'b0);
    check_bit("flush_after_fwd", es_fwd_valid, 1'b0);
    check("flush_no_capture_pc", es_pc, held_pc);
    check("flush_stall_cnt", 64'(es_stall_cnt), 64'd4);
    void'(exp_q.pop_front());
    ms_allowin = 1'b1;

    // Reset asserted mid-stall, between clock edges.
    issue(OP_ADD, 64'd8, 64'd8, 1'b0, 5'd9, 1'b1, 64'd16);
    ms_allowin = 1'b0;
    ds_valid   = 1'b0;
    @(posedge clk);
    #3;
    check("rstm_pre_stall", 64'(es_stall_cnt), 64'd5);
    check_bit("rstm_pre_valid", es_to_ms_valid, 1'b1);
    rst = 1'b1;
    #1;
    check_bit("rstm_to_ms_valid", es_to_ms_valid, 1'b0);
    check_bit("rstm_fwd_valid", es_fwd_valid, 1'b0);
    check("rstm_stall_cnt", 64'(es_stall_cnt), 64'd0);
    check_bit("rstm_allowin", es_allowin, 1'b1);
    check("rstm_result", es_result, 64'd0);
    void'(exp_q.pop_front());
    @(negedge clk);
    rst        = 1'b0;
    ms_allowin = 1'b1;
    @(posedge clk);
    #1;
    check_bit("rstm_after_allowin", es_allowin, 1'b1);

    // Operation resumes after reset.
    issue(OP_OR, 64'hF0, 64'h0F, 1'b0, 5'd10, 1'b1, 64'hFF);
    ds_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
